// File: rtl/uart_cmd_pkg.sv
// Shared RemoteComm definitions: response codes and the state encodings used by
// the UART command wrapper and its bit engines.
package uart_cmd_pkg;

  localparam logic [7:0] POS_ACK = 8'hA5;

  typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

endpackage

// File: rtl/uart_trx.sv
// UART bit engines: independent 8N1 receiver and transmitter sharing one baud divisor.
// The receiver reports a good byte via rx_rdy and a bad stop bit via rx_err.
module uart_trx
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  input  logic       send,
  input  logic [7:0] tx_byte,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       rx_active
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);

  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       rx_state, rx_nxt;
  logic [BW-1:0]   rx_baud;
  logic [3:0]      rx_bits;
  logic [7:0]      rx_shift;
  logic            rx_fall, rx_tick;

  tx_state_t       tx_state, tx_nxt;
  logic [BW-1:0]   tx_baud;
  logic [3:0]      tx_bits;
  logic [9:0]      tx_shift;
  logic            tx_tick, tx_last;

  // Sync chain presets high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall   = rx_prev & ~rx_sync;
  assign rx_tick   = (rx_state == RX_START) ? (rx_baud == BAUD_HALF) : (rx_baud == BAUD_LAST);
  assign rx_data   = rx_shift;
  assign rx_active = (rx_state != RX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_nxt;
  end

  always_comb begin
    rx_nxt = rx_state;
    rx_rdy = 1'b0;
    rx_err = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_nxt = RX_START;
      RX_START: if (rx_tick) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bits == 4'd7) rx_nxt = RX_STOP;
      RX_STOP: begin
        if (rx_tick) begin
          rx_nxt = RX_IDLE;
          rx_rdy = rx_sync;
          rx_err = ~rx_sync;
        end
      end
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_baud  <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_tick) rx_baud <= '0;
      else                                rx_baud <= rx_baud + 1'b1;
      if (rx_state != RX_DATA) rx_bits <= '0;
      else if (rx_tick)        rx_bits <= rx_bits + 1'b1;
      if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_sync, rx_shift[7:1]};
    end
  end

  // Transmit frame is held as {stop, data, start} and shifted out LSB first
  assign tx_tick = (tx_baud == BAUD_LAST);
  assign tx_last = tx_tick && (tx_bits == 4'd9);
  assign tx_busy = (tx_state == TX_SEND);
  assign tx      = (tx_state == TX_IDLE) | tx_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_nxt;
  end

  always_comb begin
    tx_nxt = tx_state;
    case (tx_state)
      TX_IDLE: if (send)    tx_nxt = TX_SEND;
      TX_SEND: if (tx_last) tx_nxt = TX_IDLE;
      default:              tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_baud  <= '0;
      tx_bits  <= '0;
      tx_shift <= '1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= (tx_state == TX_SEND) && tx_last;
      if (tx_state == TX_IDLE) begin
        tx_baud <= '0;
        tx_bits <= '0;
        if (send) tx_shift <= {1'b1, tx_byte, 1'b0};
      end else if (tx_tick) begin
        tx_baud  <= '0;
        tx_bits  <= tx_bits + 1'b1;
        tx_shift <= {1'b1, tx_shift[9:1]};
      end else begin
        tx_baud <= tx_baud + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// RemoteComm responder: pairs received bytes (high first) into 16-bit commands for
// cmd_proc and sends single-byte responses back on TX.
module uart_cmd_wrapper
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int GAP_TO   = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        frm_err
);

  localparam int GW = $clog2(GAP_TO + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TO);

  logic       rx_rdy, rx_err, rx_active;
  logic [7:0] rx_data;
  logic [7:0] high_byte;
  logic [GW-1:0] gap_cnt;
  logic       gap_timeout;
  asm_state_t asm_state, asm_nxt;

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (RX),
    .tx        (TX),
    .send      (send_resp),
    .tx_byte   (resp),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .rx_err    (rx_err),
    .rx_active (rx_active)
  );

  // Gap only runs while waiting for the low byte's start bit
  assign gap_timeout = (asm_state == ASM_LOW) && !rx_active && (gap_cnt == GAP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) asm_state <= ASM_HIGH;
    else        asm_state <= asm_nxt;
  end

  always_comb begin
    asm_nxt = asm_state;
    case (asm_state)
      ASM_HIGH: if (rx_rdy) asm_nxt = ASM_LOW;
      ASM_LOW:  if (rx_rdy || rx_err || gap_timeout) asm_nxt = ASM_HIGH;
      default:  asm_nxt = ASM_HIGH;
    endcase
  end

  // A completing low byte beats a coincident clr_cmd_rdy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt   <= '0;
      high_byte <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      if (asm_state == ASM_LOW && !rx_active && !gap_timeout) gap_cnt <= gap_cnt + 1'b1;
      else                                                    gap_cnt <= '0;
      if (asm_state == ASM_HIGH && rx_rdy) high_byte <= rx_data;
      if (asm_state == ASM_LOW && rx_rdy)  cmd <= {high_byte, rx_data};
      if (asm_state == ASM_LOW && rx_rdy)       cmd_rdy <= 1'b1;
      else if (asm_state == ASM_HIGH && rx_rdy) cmd_rdy <= 1'b0;
      else if (clr_cmd_rdy)                     cmd_rdy <= 1'b0;
      frm_err <= rx_err | gap_timeout;
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed and randomized bench for uart_cmd_wrapper: drives RemoteComm frames on RX,
// decodes TX frames by sampling bit centres, and checks against expected commands/bytes.
module tb_uart_cmd_wrapper;
  import uart_cmd_pkg::*;

  localparam int BAUD = 16;
  localparam int GAP  = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic        clr_cmd_rdy = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        tx_busy, tx_done, frm_err;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int frm_err_cnt = 0;
  int rise_cyc = -1;
  logic cmd_rdy_prev = 1'b0;
  logic [15:0] exp_q[$];

  uart_cmd_wrapper #(.BAUD_DIV(BAUD), .GAP_TO(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .send_resp   (send_resp),
    .resp        (resp),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Event monitors: frm_err pulse count and the cycle cmd_rdy last rose
  always @(negedge clk) begin
    if (frm_err === 1'b1) frm_err_cnt++;
    if (cmd_rdy === 1'b1 && cmd_rdy_prev !== 1'b1) rise_cyc = cyc;
    cmd_rdy_prev = cmd_rdy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one 8N1 frame; optionally hold clr_cmd_rdy during the stop bit until cmd_rdy appears
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input bit clr_at_stop,
                               output int start_cyc, output bit rose);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    rose = 1'b0;
    @(negedge clk);
    start_cyc = cyc;
    for (int k = 0; k < 10; k++) begin
      RX = frame[k];
      for (int c = 0; c < BAUD; c++) begin
        if (clr_at_stop && k == 9) begin
          if (cmd_rdy === 1'b1) begin
            rose = 1'b1;
            clr_cmd_rdy = 1'b0;
          end else if (!rose) begin
            clr_cmd_rdy = 1'b1;
          end
        end
        @(negedge clk);
      end
    end
    RX = 1'b1;
    if (clr_at_stop) begin
      for (int c = 0; c < 2 * BAUD && !rose; c++) begin
        if (cmd_rdy === 1'b1) rose = 1'b1;
        else                  clr_cmd_rdy = 1'b1;
        if (rose) clr_cmd_rdy = 1'b0;
        @(negedge clk);
      end
      clr_cmd_rdy = 1'b0;
    end
  endtask

  task automatic sendCmd(input logic [15:0] c, input bit clr_overlap, output int lo_start, output bit rose);
    int hs;
    bit hr;
    applyStimulus(c[15:8], 1'b1, 1'b0, hs, hr);
    applyStimulus(c[7:0], 1'b1, clr_overlap, lo_start, rose);
    repeat (2) @(negedge clk);
  endtask

  // Pulse send_resp, record TX for a whole frame, then decode it at bit centres
  task automatic txCapture(input logic [7:0] r, input bit interfere, input logic [7:0] r2,
                           output logic [7:0] got, output logic stop_ok, output bit found,
                           output int busy_n, output int done_n);
    logic trace[$];
    int idx;
    @(negedge clk);
    send_resp = 1'b1;
    resp = r;
    @(negedge clk);
    send_resp = 1'b0;
    resp = 8'h00;
    busy_n = 0;
    done_n = 0;
    for (int c = 0; c < 10 * BAUD + 30; c++) begin
      trace.push_back(TX);
      busy_n += int'(tx_busy);
      done_n += int'(tx_done);
      if (interfere && c == 3 * BAUD) begin
        send_resp = 1'b1;
        resp = r2;
      end else begin
        send_resp = 1'b0;
      end
      @(negedge clk);
    end
    idx = -1;
    for (int c = 0; c < trace.size(); c++)
      if (idx < 0 && trace[c] === 1'b0) idx = c;
    found = (idx >= 0);
    got = 8'h00;
    stop_ok = 1'b0;
    if (found) begin
      for (int k = 0; k < 8; k++) got[k] = trace[idx + BAUD / 2 + (k + 1) * BAUD];
      stop_ok = trace[idx + BAUD / 2 + 9 * BAUD];
    end
  endtask

  initial begin
    int s, lo_start, lat, e0, busy_n, done_n;
    bit rose, found;
    logic stop_ok;
    logic [7:0] got, hi, lo, rb;
    logic [15:0] expc;

    #3 rst_n = 1'b0;
    #1;
    checkOutput("reset_TX", 32'(TX), 32'd1);
    checkOutput("reset_cmd", 32'(cmd), 32'h0);
    checkOutput("reset_cmd_rdy", 32'(cmd_rdy), 32'd0);
    checkOutput("reset_tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("reset_tx_done", 32'(tx_done), 32'd0);
    checkOutput("reset_frm_err", 32'(frm_err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] step 1: command 4002");
    e0 = frm_err_cnt;
    rise_cyc = -1;
    sendCmd(16'h4002, 1'b0, lo_start, rose);
    lat = rise_cyc - (lo_start + 9 * BAUD + BAUD / 2);
    checkOutput("cmd_4002", 32'(cmd), 32'h4002);
    checkOutput("cmd_rdy_4002", 32'(cmd_rdy), 32'd1);
    checkOutput("cmd_rdy_latency_ok", 32'(lat >= 0 && lat <= 4), 32'd1);
    checkOutput("no_frm_err_4002", 32'(frm_err_cnt - e0), 32'd0);

    $display("[TB] step 2: response A5");
    txCapture(POS_ACK, 1'b0, 8'h00, got, stop_ok, found, busy_n, done_n);
    checkOutput("tx_frame_found", 32'(found), 32'd1);
    checkOutput("tx_byte_A5", 32'(got), 32'hA5);
    checkOutput("tx_stop_bit", 32'(stop_ok), 32'd1);
    checkOutput("tx_busy_cycles", 32'(busy_n), 32'(10 * BAUD));
    checkOutput("tx_done_pulses", 32'(done_n), 32'd1);
    checkOutput("tx_idle_high", 32'(TX), 32'd1);

    $display("[TB] step 3: lone high byte then gap timeout");
    e0 = frm_err_cnt;
    applyStimulus(8'h5B, 1'b1, 1'b0, s, rose);
    repeat (GAP + 10) @(negedge clk);
    checkOutput("gap_frm_err_pulse", 32'(frm_err_cnt - e0), 32'd1);
    checkOutput("gap_cmd_held", 32'(cmd), 32'h4002);
    checkOutput("gap_cmd_rdy_cleared", 32'(cmd_rdy), 32'd0);
    sendCmd(16'h47F1, 1'b0, lo_start, rose);
    checkOutput("cmd_47F1", 32'(cmd), 32'h47F1);
    checkOutput("cmd_rdy_47F1", 32'(cmd_rdy), 32'd1);

    $display("[TB] step 5a: clr_cmd_rdy alone");
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    checkOutput("clr_alone", 32'(cmd_rdy), 32'd0);

    $display("[TB] step 4: bad stop bit");
    e0 = frm_err_cnt;
    rise_cyc = -1;
    applyStimulus(8'h53, 1'b0, 1'b0, s, rose);
    repeat (BAUD) @(negedge clk);
    checkOutput("stop_frm_err_pulse", 32'(frm_err_cnt - e0), 32'd1);
    checkOutput("stop_no_cmd_rdy", 32'(cmd_rdy), 32'd0);
    checkOutput("stop_no_rise", 32'(rise_cyc), 32'hFFFF_FFFF);
    sendCmd(16'h53F2, 1'b0, lo_start, rose);
    checkOutput("cmd_53F2", 32'(cmd), 32'h53F2);

    $display("[TB] step 5b: clr_cmd_rdy coincident with completion");
    sendCmd(16'hC3A6, 1'b1, lo_start, rose);
    checkOutput("set_seen_with_clr", 32'(rose), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("set_wins", 32'(cmd_rdy), 32'd1);
    checkOutput("cmd_C3A6", 32'(cmd), 32'hC3A6);

    $display("[TB] random commands and responses");
    for (int i = 0; i < 5; i++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      exp_q.push_back({hi, lo});
      sendCmd({hi, lo}, 1'b0, lo_start, rose);
      expc = exp_q.pop_front();
      checkOutput("rand_cmd", 32'(cmd), 32'(expc));
      checkOutput("rand_cmd_rdy", 32'(cmd_rdy), 32'd1);
      if (i < 2) begin
        rb = 8'($urandom);
        txCapture(rb, 1'b0, 8'h00, got, stop_ok, found, busy_n, done_n);
        checkOutput("rand_tx_byte", 32'(got), 32'(rb));
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    $display("[TB] step 6: reset mid-frame");
    @(negedge clk);
    send_resp = 1'b1;
    resp = POS_ACK;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (2 * BAUD) @(negedge clk);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      hi = 8'h47;
      RX = hi[k];
      repeat (BAUD) @(negedge clk);
    end
    checkOutput("pre_reset_tx_busy", 32'(tx_busy), 32'd1);
    checkOutput("pre_reset_cmd_rdy", 32'(cmd_rdy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_TX", 32'(TX), 32'd1);
    checkOutput("mid_reset_tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("mid_reset_cmd_rdy", 32'(cmd_rdy), 32'd0);
    checkOutput("mid_reset_cmd", 32'(cmd), 32'h0);
    RX = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    e0 = frm_err_cnt;
    sendCmd(16'h4002, 1'b0, lo_start, rose);
    checkOutput("post_reset_cmd", 32'(cmd), 32'h4002);
    checkOutput("post_reset_cmd_rdy", 32'(cmd_rdy), 32'd1);
    checkOutput("post_reset_no_frm_err", 32'(frm_err_cnt - e0), 32'd0);
    txCapture(POS_ACK, 1'b1, 8'h3C, got, stop_ok, found, busy_n, done_n);
    checkOutput("busy_ignore_byte", 32'(got), 32'hA5);
    checkOutput("busy_ignore_cycles", 32'(busy_n), 32'(10 * BAUD));
    checkOutput("busy_ignore_done", 32'(done_n), 32'd1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
